prog_ctr: RTL
=============

# prog_ctr

Program-counter and fetch sequencer for the 8-bit core. It generates the instruction address, advances it every cycle, and redirects it on a taken `bneg` using the ALU's `zero` flag and an internal branch-target LUT. It halts on opcode `000` and holds the address during load/store memory wait cycles. It sits upstream of instruction memory and decode, so it feeds the ALU stage, and it consumes that stage's `zero` result in the same cycle.

## Interface
Parameters:
- `PC_W`, default 10: width of the PC and of the LUT entries.
- `TGT_W`, default 5: LUT index width (2^TGT_W entries).

Ports:
- `CLK`  in  1: clock. Everything updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Start`  in  1: level request to run the program from address 0.
- `OP`  in  3: opcode of the instruction currently at `PC`.
- `Zero`  in  1: ALU `zero` flag for the current instruction. For `bneg`, `Zero=1` means the operand was negative.
- `Target`  in  TGT_W: LUT index taken from the current instruction.
- `Stall`  in  1: memory wait for `ld`/`st`. High holds all state except the LUT and the cycle counter.
- `LutWe`  in  1: LUT write enable.
- `LutAddr`  in  TGT_W: LUT write index.
- `LutData`  in  PC_W: LUT write data, an absolute target address.
- `PC`  out  PC_W: registered instruction address.
- `Running`  out  1: high in RUN.
- `Done`  out  1: high in HALT.
- `BrTaken`  out  1: registered one-cycle pulse, high in the first cycle that shows a branch target on `PC`.
- `CycleCnt`  out  16: present only with `PROG_CTR_CYCLE_CNT_EN`.

## Operation
- Three states: IDLE, RUN, HALT.
  - IDLE: `PC` is held at 0. Moves to RUN when `Start=1`.
  - RUN: per-cycle update, in priority order:
    1. `Stall=1`: hold `PC` and state. `OP` is ignored, halt included.
    2. `OP=000`: go to HALT and hold `PC`.
    3. `OP=010` and `Zero=1`: `PC <= LUT[Target]` and `BrTaken <= 1`.
    4. Otherwise: `PC <= PC+1`, truncated to PC_W bits, so `2^PC_W-1` wraps to 0.
  - HALT: `PC` holds the address of the halting instruction and `Done=1`. Moves to IDLE when `Start=0`.
  - A new run needs `Start` to go low, then high.
- `OP=010` with `Zero=0` is an ordinary increment.
- All opcodes other than `000` and `010` increment.
- LUT:
  - 2^TGT_W entries of PC_W bits, cleared to 0 by `Reset`.
  - Writable in any state, including during a stall.
  - If a write and a branch hit the same entry in the same cycle, the branch uses the old contents. The new value is visible from the next cycle.
- `Reset` overrides everything.
  - Clears the state to IDLE, the LUT and the counter.
  - Output reset values: `PC=0`, `Running=0`, `Done=0`, `BrTaken=0`, `CycleCnt=0`.
  - Reset mid-run discards the run. Reaching RUN again requires `Start=1` after `Reset` is released.
- Leaving IDLE loads `PC=0`, so the first fetched address is always 0.

## Timing
- One cycle of latency from inputs to `PC`.
- `OP`, `Zero` and `Target` are sampled at the edge. They are combinational functions of the current `PC`, through instruction memory and the ALU.
- IDLE→RUN:
  - `Start` is sampled high at edge N.
  - After edge N: `Running=1`, `PC=0`.
  - Instruction 0 is decided at edge N+1.
- Branch decided at edge N: after edge N, `PC=target` and `BrTaken=1`. After edge N+1, `BrTaken=0` unless another branch is taken.
- `Done` rises in the cycle after the edge that samples `OP=000`. `Running` falls in the same cycle.
- One `Stall` cycle adds exactly one cycle to the instruction.

## Configuration
- `PROG_CTR_CYCLE_CNT_EN` defined:
  - Adds the 16-bit `CycleCnt` port.
  - Clears to 0 on the IDLE→RUN transition.
  - Increments on every RUN cycle, stall cycles included.
  - Saturates at `16'hFFFF`.
  - Holds in HALT and IDLE.
- Not defined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `Start=1` with `OP=100` every cycle → `PC` reads 0,1,2,3 on successive cycles with `Running=1`. Assert `Reset` at `PC=3` → next cycle `PC=0`, state IDLE.
- Write `LUT[5]=10'h123`, then present `OP=010`, `Zero=1`, `Target=5` at `PC=7` → next cycle `PC=0x123`, `BrTaken=1`. The following cycle `BrTaken=0` and `PC=0x124`.
- Same as the previous case with `Zero=0` → `PC=8` and `BrTaken` stays 0.
- `OP=110` with `Stall=1` for two cycles at `PC=4` → `PC` holds 4 for both cycles, then 5. `OP=000` with `Stall=1` does not halt.
- `OP=000` at `PC=9` → `Done=1`, `Running=0`, `PC` holds 9. Then `Start=0` → IDLE with `PC=0`, then `Start=1` → RUN.
- Force `PC=10'h3FF` via a branch to `LUT=10'h3FF` and present `OP=100` → `PC=0`. With the macro defined, 20 RUN cycles including 2 stalls → `CycleCnt=20` after the halt.

Source files
------------

// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer: IDLE/RUN/HALT FSM, branch-target LUT, stall hold.
// Optional 16-bit RUN cycle counter enabled by defining PROG_CTR_CYCLE_CNT_EN.
module prog_ctr #(
  parameter int PC_W  = 10,
  parameter int TGT_W = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       OP,
  input  logic             Zero,
  input  logic [TGT_W-1:0] Target,
  input  logic             Stall,
  input  logic             LutWe,
  input  logic [TGT_W-1:0] LutAddr,
  input  logic [PC_W-1:0]  LutData,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic             BrTaken
`ifdef PROG_CTR_CYCLE_CNT_EN
  ,
  output logic [15:0]      CycleCnt
`endif
);

  // state  | meaning
  // S_IDLE | PC held at 0, waiting for Start
  // S_RUN  | fetching: stall / halt / branch / increment
  // S_HALT | PC holds halting address, waiting for Start low
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_BNEG = 3'b010;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic              r_br;
  logic              w_br_nxt;
  logic [PC_W-1:0]   r_lut [2**TGT_W];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_br_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pc_nxt = '0;
        if (Start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (Stall) begin
          w_pc_nxt = r_pc;
        end else if (OP == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else if (OP == OP_BNEG && Zero) begin
          // Reads the pre-write LUT contents even if the same entry is written this cycle.
          w_pc_nxt = r_lut[Target];
          w_br_nxt = 1'b1;
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      S_HALT: begin
        if (!Start) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_br    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_br    <= w_br_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 2**TGT_W; i++) r_lut[i] <= '0;
    end else if (LutWe) begin
      r_lut[LutAddr] <= LutData;
    end
  end

  assign PC      = r_pc;
  assign Running = (r_state == S_RUN);
  assign Done    = (r_state == S_HALT);
  assign BrTaken = r_br;

`ifdef PROG_CTR_CYCLE_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE && w_state_nxt == S_RUN) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign CycleCnt = r_cnt;
`endif

endmodule
